// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead add/subtract, one BLOCK-bit lookahead slice per stage.
// Latency: NSTG cycles from input transfer to out_valid; one operation per cycle.
// Backpressure: whole pipe holds when out_valid && !out_ready; in_ready mirrors advance.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NSTG = WIDTH / BLOCK;

    // Rank 0 holds the captured operands; rank k+1 holds the state after CLA stage k.
    logic             v_q [NSTG+1];
    logic             s_q [NSTG+1];
    logic             c_q [NSTG+1];
    logic [WIDTH-1:0] a_q [NSTG+1];
    logic [WIDTH-1:0] b_q [NSTG+1];
    logic [WIDTH-1:0] r_q [NSTG+1];
    logic             ovf_q;
    logic             zero_q;

    logic [BLOCK-1:0] p_w  [NSTG];
    logic [BLOCK-1:0] g_w  [NSTG];
    logic [BLOCK:0]   cy_w [NSTG];
    logic [WIDTH-1:0] r_d  [NSTG];
    logic             ovf_d;
    logic             zero_d;
    logic             adv;

    assign adv       = !v_q[NSTG] || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[NSTG];
    assign R         = r_q[NSTG];
    assign cout      = c_q[NSTG];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    always_comb begin
        logic             cc;
        logic             term;
        logic [BLOCK-1:0] b_eff;
        logic             sa;
        logic             sb;
        cc     = 1'b0;
        term   = 1'b0;
        b_eff  = '0;
        for (int k = 0; k < NSTG; k++) begin
            b_eff  = s_q[k] ? ~b_q[k][k*BLOCK +: BLOCK] : b_q[k][k*BLOCK +: BLOCK];
            p_w[k] = a_q[k][k*BLOCK +: BLOCK] ^ b_eff;
            g_w[k] = a_q[k][k*BLOCK +: BLOCK] & b_eff;
            // Each carry is a flat sum of products of g/p and the stage carry-in.
            for (int i = 0; i <= BLOCK; i++) begin
                cc = c_q[k];
                for (int m = 0; m < i; m++) begin
                    cc = cc & p_w[k][m];
                end
                for (int j = 0; j < i; j++) begin
                    term = g_w[k][j];
                    for (int m = j + 1; m < i; m++) begin
                        term = term & p_w[k][m];
                    end
                    cc = cc | term;
                end
                cy_w[k][i] = cc;
            end
            r_d[k] = r_q[k];
            r_d[k][k*BLOCK +: BLOCK] = p_w[k] ^ cy_w[k][BLOCK-1:0];
        end
        sa     = a_q[NSTG-1][WIDTH-1];
        sb     = s_q[NSTG-1] ? ~b_q[NSTG-1][WIDTH-1] : b_q[NSTG-1][WIDTH-1];
        ovf_d  = (sa == sb) && (r_d[NSTG-1][WIDTH-1] != sa);
        zero_d = (r_d[NSTG-1] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= NSTG; k++) begin
                v_q[k] <= 1'b0;
                s_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b1;
        end else if (adv) begin
            v_q[0] <= in_valid;
            s_q[0] <= sub;
            c_q[0] <= sub ? ~cin : cin;
            a_q[0] <= A;
            b_q[0] <= B;
            r_q[0] <= '0;
            for (int k = 0; k < NSTG; k++) begin
                v_q[k+1] <= v_q[k];
                s_q[k+1] <= s_q[k];
                c_q[k+1] <= cy_w[k][BLOCK];
                a_q[k+1] <= a_q[k];
                b_q[k+1] <= b_q[k];
                r_q[k+1] <= r_d[k];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed vectors, scoreboard queue, decoupled monitor.
module tb_pipelined_cla_adder;
    typedef struct packed {
        logic [15:0] r;
        logic        c;
        logic        o;
        logic        z;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] R;
    logic        cout;
    logic        ovf;
    logic        zero;

    res_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   run = 0;
    int   max_run = 0;

    pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .R(R), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic s);
        logic [16:0] t;
        res_t        x;
        if (s) t = {1'b0, a} + {1'b0, ~b} + {16'b0, ~ci};
        else   t = {1'b0, a} + {1'b0, b} + {16'b0, ci};
        x.r = t[15:0];
        x.c = t[16];
        if (s) x.o = (a[15] != b[15]) && (t[15] != a[15]);
        else   x.o = (a[15] == b[15]) && (t[15] != a[15]);
        x.z = (t[15:0] == 16'h0);
        return x;
    endfunction

    // Called at a negedge; returns at the negedge after the input transfer.
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic s, input res_t e);
        int n = 0;
        A = a; B = b; cin = ci; sub = s; in_valid = 1'b1;
        #4;
        while (!in_ready && n <= 50) begin
            @(negedge clk);
            #4;
            n++;
        end
        if (in_ready) sb.push_back(e);
        else chk("send_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: samples just before each rising edge, pops on every output transfer.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            #4;
            if (out_valid && out_ready) begin
                run++;
                if (run > max_run) max_run = run;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got R=%h want none", R);
                end else begin
                    e = sb.pop_front();
                    chk("result", {13'b0, R, cout, ovf, zero}, {13'b0, e});
                end
            end else begin
                run = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] va [8] = '{16'h0001, 16'h7FFF, 16'hABCD, 16'hFFFF,
                            16'h8000, 16'h1357, 16'h0F0F, 16'h4000};
    logic [15:0] vb [8] = '{16'h0001, 16'h0001, 16'h1234, 16'hFFFF,
                            16'h8000, 16'h2468, 16'hF0F0, 16'h4000};
    logic [7:0]  vc = 8'b1010_0110;
    logic [7:0]  vs = 8'b0110_1100;

    initial begin
        int early;
        int n;
        out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outs", {13'b0, R, cout, ovf, zero}, {13'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);

        // Basic add with latency check.
        send(16'h1234, 16'h4321, 1'b0, 1'b0, res_t'{16'h5555, 1'b0, 1'b0, 1'b0});
        early = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) early++;
            @(negedge clk);
        end
        chk("latency_early", 32'(early), 32'd0);
        chk("latency_valid", 32'(out_valid), 32'd1);
        repeat (2) @(negedge clk);

        // Carry chain and subtract corners.
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, res_t'{16'h0000, 1'b1, 1'b0, 1'b1});
        send(16'h8000, 16'h0001, 1'b0, 1'b1, res_t'{16'h7FFF, 1'b1, 1'b1, 1'b0});
        send(16'h0000, 16'h0001, 1'b0, 1'b1, res_t'{16'hFFFF, 1'b0, 1'b0, 1'b0});
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, res_t'{16'h8000, 1'b0, 1'b1, 1'b0});
        repeat (8) @(negedge clk);

        // Back-to-back stream.
        max_run = 0;
        for (int i = 0; i < 8; i++) send(va[i], vb[i], vc[i], vs[i], model(va[i], vb[i], vc[i], vs[i]));
        repeat (8) @(negedge clk);
        chk("b2b_run", 32'(max_run), 32'd8);
        chk("b2b_drain", 32'(sb.size()), 32'd0);

        // Stall with results in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(va[i], vb[7-i], vs[i], vc[i], model(va[i], vb[7-i], vs[i], vc[i]));
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        max_run = 0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            if (sb.size() > 0) chk("stall_hold", {13'b0, R, cout, ovf, zero}, {13'b0, sb[0]});
            @(negedge clk);
        end
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("stall_run", 32'(max_run), 32'd4);
        chk("stall_drain", 32'(sb.size()), 32'd0);

        // Asynchronous reset with operations in flight.
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 1'b0, res_t'{16'h3333, 1'b0, 1'b0, 1'b0});
        send(16'h5000, 16'h3000, 1'b0, 1'b0, res_t'{16'h8000, 1'b0, 1'b1, 1'b0});
        send(16'h0010, 16'h0001, 1'b1, 1'b1, res_t'{16'h000E, 1'b1, 1'b0, 1'b0});
        repeat (4) @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_outs", {13'b0, R, cout, ovf, zero}, {13'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("no_stale", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits; SHALL be a positive multiple of BLOCK.
REQ-002 Parameter BLOCK, default 4, bits per carry-lookahead block, one block per pipeline stage.
REQ-003 NSTG SHALL be a derived localparam equal to WIDTH/BLOCK and SHALL equal the pipeline depth in cycles.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operand set present on A, B, cin, sub.
REQ-007 in_ready  output  1  block accepts an operand set this cycle.
REQ-008 A  input  WIDTH  operand A.
REQ-009 B  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in (add) / borrow-in (subtract).
REQ-011 sub  input  1  0 = add, 1 = subtract.
REQ-012 out_valid  output  1  R, cout, ovf, zero hold a completed result.
REQ-013 out_ready  input  1  downstream accepts the result this cycle.
REQ-014 R  output  WIDTH  sum/difference.
REQ-015 cout  output  1  carry out of bit WIDTH-1.
REQ-016 ovf  output  1  two's-complement signed overflow.
REQ-017 zero  output  1  R equals 0.

Function
REQ-018 Add: {cout,R} SHALL equal A + B + cin, modulo 2^(WIDTH+1).
REQ-019 Subtract: the block SHALL compute A + ~B + ~cin, i.e. R = A - B - cin; cout=1 means no borrow.
REQ-020 Each stage SHALL be a BLOCK-bit carry-lookahead slice using per-bit propagate (A^B') and generate (A&B'), with no ripple between bits inside the slice.
REQ-021 Stage k SHALL compute bits [k*BLOCK +: BLOCK] from the carry registered by stage k-1; stage 0 SHALL use the effective carry-in.
REQ-022 Operand bits not yet consumed and result bits already produced SHALL be carried forward in per-stage registers alongside the stage's valid bit and the mode bit.
REQ-023 A transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-024 Latency SHALL be exactly NSTG cycles from the input-transfer edge to out_valid=1, absent stalls.
REQ-025 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-026 Advance signal SHALL equal (!out_valid || out_ready); all stages shift only when advance=1, otherwise every stage holds.
REQ-027 in_ready SHALL equal advance, combinationally.
REQ-028 Bubbles (stages with valid=0) SHALL propagate as bubbles and SHALL NOT produce out_valid.
REQ-029 While out_valid=1 and out_ready=0, R, cout, ovf, zero SHALL remain stable.
REQ-030 ovf SHALL equal (sign of A == sign of effective B) && (sign of R != sign of A), computed in the final stage.
REQ-031 zero SHALL be registered with R and SHALL be 1 exactly when R == 0.
REQ-032 Input transfer and output transfer in the same cycle SHALL both succeed with no lost or duplicated result.
REQ-033 Carry out of bit WIDTH-1 SHALL NOT wrap into bit 0; only cout reflects it.

Reset
REQ-034 rst_n=0 SHALL immediately clear all stage valid bits, out_valid, R, cout, ovf; zero SHALL reset to 1.
REQ-035 Operations in flight at reset assertion SHALL be discarded; no result from them SHALL ever appear.
REQ-036 On the first rising clk edge after rst_n rises, in_ready SHALL be 1 and out_valid SHALL be 0.

Verification (WIDTH=16, BLOCK=4, NSTG=4)
REQ-037 Add A=0x1234, B=0x4321, cin=0, out_ready=1 -> 4 cycles later out_valid=1, R=0x5555, cout=0, ovf=0, zero=0.
REQ-038 Full carry chain A=0xFFFF, B=0x0000, cin=1 -> R=0x0000, cout=1, zero=1, ovf=0.
REQ-039 Subtract A=0x8000, B=0x0001, cin=0, sub=1 -> R=0x7FFF, cout=1, ovf=1; subtract A=0x0000, B=0x0001 -> R=0xFFFF, cout=0, ovf=0.
REQ-040 Back-to-back 8 random operations with out_ready=1 -> 8 consecutive out_valid cycles, results in order, matching reference arithmetic.
REQ-041 Hold out_ready=0 for 5 cycles with pipeline full -> in_ready=0, outputs stable; release -> all 4 results delivered in order, none lost or repeated.
REQ-042 Assert rst_n=0 mid-cycle with 3 operations in flight -> outputs clear without a clock edge; after release, no stale result appears.
